atm_counter_reader: RTL and testbench

ATM_COUNTER_READER -- requirements
Module: atm_counter_reader

---
 rtl/atm_rdr_pkg.sv | 16 +
 rtl/atm_rdr_period_timer.sv | 34 +++
 rtl/atm_counter_reader.sv | 108 ++++++++++
 tb/tb_atm_counter_reader.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/atm_rdr_pkg.sv
// Shared types and widths for the coherent 64-bit counter reader.
package atm_rdr_pkg;

    localparam int BUS_W = 32;
    localparam int CNT_W = 64;
    localparam int PER_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        REQ_LO,
        REQ_HI,
        WAIT_HI,
        DONE
    } state_e;

endpackage

// File: rtl/atm_rdr_period_timer.sv
// Free-running auto-read period timer: emits one tick every PERIOD cycles while en is high.
module atm_rdr_period_timer
    import atm_rdr_pkg::*;
#(
    parameter int PERIOD = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [PER_W-1:0] RELOAD = PER_W'(PERIOD - 1);

    logic [PER_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = tick ? RELOAD : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/atm_counter_reader.sv
// Reads a 64-bit counter as two back-to-back 32-bit beats (LSB first) so the pair is coherent.
// Optional ATM_RDR_DELTA_EN adds delta_o = new count minus previous count.
module atm_counter_reader
    import atm_rdr_pkg::*;
#(
    parameter int AUTO_PERIOD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             ack_i,
    input  logic [BUS_W-1:0] data_i,
    output logic             req_o,
    output logic             atomic_o,
    output logic [CNT_W-1:0] count_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             err_o
`ifdef ATM_RDR_DELTA_EN
    ,
    output logic [CNT_W-1:0] delta_o
`endif
);

    state_e           state_q, state_d;
    logic [BUS_W-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic             auto_tick;

    atm_rdr_period_timer #(
        .PERIOD(AUTO_PERIOD)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (AUTO_PERIOD != 0),
        .tick(auto_tick)
    );

    assign req_o    = (state_q == REQ_LO) || (state_q == REQ_HI);
    assign atomic_o = (state_q == REQ_LO);
    assign busy_o   = (state_q != IDLE);
    assign valid_o  = (state_q == DONE);
    assign count_o  = count_q;
    assign err_o    = err_q;

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        count_d = count_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE:    if (start_i || auto_tick) state_d = REQ_LO;
            REQ_LO:  state_d = REQ_HI;
            REQ_HI: begin
                // Ack here answers the LSB beat issued in REQ_LO.
                if (ack_i) begin
                    lo_d    = data_i;
                    state_d = WAIT_HI;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_HI: begin
                if (ack_i) begin
                    count_d = {data_i, lo_q};
                    state_d = DONE;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lo_q    <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

`ifdef ATM_RDR_DELTA_EN
    logic [CNT_W-1:0] delta_q;

    // count_q still holds the previous value on the capture edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            delta_q <= '0;
        end else if (state_q == WAIT_HI && ack_i) begin
            delta_q <= {data_i, lo_q} - count_q;
        end
    end

    assign delta_o = delta_q;
`endif

endmodule

// File: tb/tb_atm_counter_reader.sv
// Self-checking bench: free-running 64-bit counter model with a one-cycle-lagged MSB snapshot.
module tb_atm_counter_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, ack_a = 1'b0, start_b = 1'b0, ack_b = 1'b0;
    logic [31:0] data_a = '0, data_b = '0;
    logic        req_a, atomic_a, valid_a, busy_a, err_a;
    logic        req_b, atomic_b, valid_b, busy_b, err_b;
    logic [63:0] count_a, count_b;
`ifdef ATM_RDR_DELTA_EN
    logic [63:0] delta_a, delta_b;
`endif

    always #5 clk = ~clk;

    atm_counter_reader #(.AUTO_PERIOD(0)) dut (
        .clk(clk), .rst(rst), .start_i(start_a), .ack_i(ack_a), .data_i(data_a),
        .req_o(req_a), .atomic_o(atomic_a), .count_o(count_a), .valid_o(valid_a),
        .busy_o(busy_a), .err_o(err_a)
`ifdef ATM_RDR_DELTA_EN
        , .delta_o(delta_a)
`endif
    );

    atm_counter_reader #(.AUTO_PERIOD(10)) dut_auto (
        .clk(clk), .rst(rst), .start_i(start_b), .ack_i(ack_b), .data_i(data_b),
        .req_o(req_b), .atomic_o(atomic_b), .count_o(count_b), .valid_o(valid_b),
        .busy_o(busy_b), .err_o(err_b)
`ifdef ATM_RDR_DELTA_EN
        , .delta_o(delta_b)
`endif
    );

    // Counter model: live value increments while trig; LSB request snapshots all 64 bits.
    logic [63:0] cnt = '0, snap = '0, load_val = '0;
    logic        trig = 1'b0, load_req = 1'b0, drop_lo = 1'b0, drop_hi = 1'b0;

    always @(posedge clk) begin
        cnt   <= load_req ? load_val : cnt + 64'(trig);
        ack_a <= 1'b0;
        data_a <= $urandom;
        if (req_a && atomic_a) begin
            snap   <= cnt;
            ack_a  <= !drop_lo;
            data_a <= cnt[31:0];
        end else if (req_a && !atomic_a) begin
            ack_a  <= !drop_hi;
            data_a <= snap[63:32];
        end
        ack_b  <= req_b;
        data_b <= atomic_b ? 32'h0000_000A : 32'h0000_000B;
    end

    int nlo = 0, nhi = 0, nval = 0, nerr = 0;
    always @(negedge clk) begin
        if (req_a && atomic_a)  nlo++;
        if (req_a && !atomic_a) nhi++;
        if (valid_a)            nval++;
        if (err_a)              nerr++;
    end

    int          ntest = 0, nfail = 0;
    logic [63:0] last = '0, prev = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntest++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Loads the model counter, issues one start and checks the 4-cycle read sequence.
    task automatic do_read(input logic [63:0] v, input logic t, input string tag);
        logic [63:0] exp;
        trig = t; load_req = 1'b1; load_val = v;
        @(negedge clk);
        load_req = 1'b0;
        exp = cnt + 64'(trig);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk({tag, "/lo_beat"}, {62'd0, req_a, atomic_a}, 64'd3);
        @(negedge clk);
        chk({tag, "/hi_beat"}, {62'd0, req_a, atomic_a}, 64'd2);
        @(negedge clk);
        chk({tag, "/wait"}, {62'd0, req_a, valid_a}, 64'd0);
        @(negedge clk);
        chk({tag, "/valid"}, {63'd0, valid_a}, 64'd1);
        chk({tag, "/count"}, count_a, exp);
`ifdef ATM_RDR_DELTA_EN
        chk({tag, "/delta"}, delta_a, exp - prev);
`endif
        prev = exp; last = exp;
        @(negedge clk);
        chk({tag, "/idle"}, {62'd0, busy_a, valid_a}, 64'd0);
    endtask

    task automatic err_read(input logic lo_miss, input string tag);
        drop_lo = lo_miss; drop_hi = !lo_miss; trig = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (2) @(negedge clk);
        if (!lo_miss) @(negedge clk);
        chk({tag, "/err"}, {61'd0, err_a, valid_a, busy_a}, 64'd4);
        chk({tag, "/count_kept"}, count_a, last);
        @(negedge clk);
        chk({tag, "/after"}, {62'd0, err_a, valid_a}, 64'd0);
        chk({tag, "/count_kept2"}, count_a, last);
        drop_lo = 1'b0; drop_hi = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int b_lo, b_hi, b_v, b_e, n;

        repeat (2) @(negedge clk);
        chk("rst/outs_a", {58'd0, req_a, atomic_a, valid_a, busy_a, err_a, 1'b0}, 64'd0);
        chk("rst/count_a", count_a, 64'd0);
        chk("rst/outs_b", {60'd0, req_b, valid_b, busy_b, err_b}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // MSB snapshot must come from the LSB cycle, not the live counter that has rolled over.
        do_read(64'h0000_0001_FFFF_FFFE, 1'b1, "coherent");
        chk("coherent/msb", {32'd0, count_a[63:32]}, 64'd1);

        do_read(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "wrap");
        do_read(64'hFFFF_FFFF_FFFF_FFFE, 1'b1, "allones");
        for (int i = 0; i < 8; i++) begin
            do_read({$urandom, $urandom}, 1'($urandom_range(0, 1)), "rand");
        end

        err_read(1'b0, "miss_hi");
        err_read(1'b1, "miss_lo");
        do_read({$urandom, $urandom}, 1'b1, "post_err");

        // start_i held through the read: one beat pair, one valid.
        b_lo = nlo; b_hi = nhi; b_v = nval;
        start_a = 1'b1;
        repeat (4) @(negedge clk);
        start_a = 1'b0;
        repeat (6) @(negedge clk);
        chk("repeat/lo", 64'(nlo - b_lo), 64'd1);
        chk("repeat/hi", 64'(nhi - b_hi), 64'd1);
        chk("repeat/valid", 64'(nval - b_v), 64'd1);
        last = {snap};
        prev = last;

        // Reset in REQ_HI aborts silently.
        trig = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        chk("rstmid/in_hi", {62'd0, req_a, atomic_a}, 64'd2);
        rst = 1'b1;
        b_v = nval; b_e = nerr;
        @(negedge clk);
        chk("rstmid/outs", {60'd0, req_a, busy_a, valid_a, err_a}, 64'd0);
        chk("rstmid/count", count_a, 64'd0);
        rst = 1'b0;
        prev = '0; last = '0;
        repeat (6) @(negedge clk);
        chk("rstmid/no_valid", 64'(nval - b_v), 64'd0);
        chk("rstmid/no_err", 64'(nerr - b_e), 64'd0);

        do_read(64'h10, 1'b0, "delta1");
        do_read(64'h25, 1'b0, "delta2");

        // Auto-read: first tick 9 cycles after reset, valid 4 cycles later, then every 10.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        b_v = nval;
        n = 0;
        for (int i = 0; i < 104; i++) begin
            if (valid_b) begin
                chk("auto/offset", 64'(i), 64'(13 + 10 * n));
                n++;
            end
            start_b = (i == 9 || i == 11);
            @(negedge clk);
        end
        start_b = 1'b0;
        chk("auto/pulses", 64'(n), 64'd10);
        chk("auto/count", count_b, 64'h0000_000B_0000_000A);
        chk("auto/a_disabled", 64'(nval - b_v), 64'd0);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
